// File: rtl/out_bus_pkg.sv
// rtl/out_bus_pkg.sv - shared constants, state encoding and grant helpers for the output bus arbiter
package out_bus_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [NUM_REQ-1:0] GNT_NONE = '0;
  localparam logic [NUM_REQ-1:0] GNT_LSB  = NUM_REQ'(1);

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    return GNT_LSB << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational rotating-priority pick of one of four requests starting at ptr
module rr_pick4
  import out_bus_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   win
);

  logic [SEL_W-1:0] w_idx;

  // Scan from the farthest offset back to ptr so the nearest set bit wins.
  always_comb begin
    any   = |req;
    win   = ptr;
    w_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = ptr + SEL_W'(k);
      if (req[w_idx]) begin
        win = w_idx;
      end
    end
  end

endmodule

// File: rtl/out_bus_rr_arbiter.sv
// rtl/out_bus_rr_arbiter.sv - round-robin owner of a shared output bus with per-grant word limit
module out_bus_rr_arbiter
  import out_bus_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req,
  input  logic [WIDTH-1:0]    d0,
  input  logic [WIDTH-1:0]    d1,
  input  logic [WIDTH-1:0]    d2,
  input  logic [WIDTH-1:0]    d3,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [SEL_W-1:0]    sel,
  output logic                busy,
  output logic [WIDTH-1:0]    y,
  output logic                y_valid
);

  localparam int                HOLD_W    = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t              r_state, w_state_nx;
  logic [NUM_REQ-1:0]  r_gnt, w_gnt_nx;
  logic [SEL_W-1:0]    r_sel, w_sel_nx;
  logic [SEL_W-1:0]    r_ptr, w_ptr_nx;
  logic [HOLD_W-1:0]   r_hold_cnt, w_hold_cnt_nx;
  logic [WIDTH-1:0]    r_y, w_y_nx;
  logic                r_y_valid, w_y_valid_nx;
  logic                w_any;
  logic [SEL_W-1:0]    w_win;
  logic [WIDTH-1:0]    w_mux;

  rr_pick4 u_pick (
    .req (req),
    .ptr (r_ptr),
    .any (w_any),
    .win (w_win)
  );

  // In BUSY r_sel is the grantee, so the registered select drives the mux.
  always_comb begin
    case (r_sel)
      2'd0:    w_mux = d0;
      2'd1:    w_mux = d1;
      2'd2:    w_mux = d2;
      default: w_mux = d3;
    endcase
  end

  always_comb begin
    w_state_nx    = r_state;
    w_gnt_nx      = r_gnt;
    w_sel_nx      = r_sel;
    w_ptr_nx      = r_ptr;
    w_hold_cnt_nx = r_hold_cnt;
    w_y_nx        = r_y;
    w_y_valid_nx  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nx    = ST_BUSY;
          w_gnt_nx      = idx_to_onehot(w_win);
          w_sel_nx      = w_win;
          w_hold_cnt_nx = '0;
        end
      end
      default: begin
        if (req[r_sel]) begin
          w_y_nx       = w_mux;
          w_y_valid_nx = 1'b1;
        end
        // A drop on the limit edge is a plain drop: no word, same release.
        if (!req[r_sel] || r_hold_cnt == HOLD_LAST) begin
          w_state_nx = ST_IDLE;
          w_gnt_nx   = GNT_NONE;
          w_ptr_nx   = r_sel + SEL_W'(1);
        end else begin
          w_hold_cnt_nx = r_hold_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_gnt      <= GNT_NONE;
      r_sel      <= '0;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_y        <= '0;
      r_y_valid  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_gnt      <= w_gnt_nx;
      r_sel      <= w_sel_nx;
      r_ptr      <= w_ptr_nx;
      r_hold_cnt <= w_hold_cnt_nx;
      r_y        <= w_y_nx;
      r_y_valid  <= w_y_valid_nx;
    end
  end

  assign gnt     = r_gnt;
  assign sel     = r_sel;
  assign busy    = (r_state == ST_BUSY);
  assign y       = r_y;
  assign y_valid = r_y_valid;

endmodule

// File: tb/tb_out_bus_rr_arbiter.sv
// tb/tb_out_bus_rr_arbiter.sv - directed self-checking bench for out_bus_rr_arbiter
module tb_out_bus_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, req1;
  logic [7:0] d0, d1, d2, d3;
  logic [3:0] gnt, gnt1;
  logic [1:0] sel, sel1;
  logic       busy, busy1;
  logic [7:0] y, y1;
  logic       y_valid, y_valid1;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] dv;
  logic [1:0] gv;
  logic [7:0] dat [4];

  always #5 clk = ~clk;

  out_bus_rr_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .gnt(gnt), .sel(sel), .busy(busy), .y(y), .y_valid(y_valid)
  );

  out_bus_rr_arbiter #(.WIDTH(8), .MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .gnt(gnt1), .sel(sel1), .busy(busy1), .y(y1), .y_valid(y_valid1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req = 4'b0; req1 = 4'b0;
    d0 = 8'h00; d1 = 8'h00; d2 = 8'h00; d3 = 8'h00;
    tick(); tick();
    chk4("rst_gnt", gnt, 4'b0000);
    chk2("rst_sel", sel, 2'd0);
    chk1("rst_busy", busy, 1'b0);
    chk8("rst_y", y, 8'h00);
    chk1("rst_yv", y_valid, 1'b0);
    chk4("rst_gnt1", gnt1, 4'b0000);
    rst = 1'b0;

    // reset in the middle of a grant
    d0 = 8'hA5; req = 4'b0001;
    tick();
    chk4("a_gnt", gnt, 4'b0001);
    chk1("a_busy", busy, 1'b1);
    tick();
    chk8("a_y", y, 8'hA5);
    chk1("a_yv", y_valid, 1'b1);
    rst = 1'b1;
    tick();
    chk4("a_rst_gnt", gnt, 4'b0000);
    chk1("a_rst_busy", busy, 1'b0);
    chk8("a_rst_y", y, 8'h00);
    chk1("a_rst_yv", y_valid, 1'b0);
    chk2("a_rst_ptr", dut.r_ptr, 2'd0);
    rst = 1'b0;
    tick();
    chk4("a_regnt", gnt, 4'b0001);
    req = 4'b0000;
    tick();
    chk1("a_rel_busy", busy, 1'b0);
    chk1("a_rel_yv", y_valid, 1'b0);
    tick();

    // single requester, four words per grant, then an idle cycle
    req = 4'b0100; d2 = 8'h10;
    tick();
    chk4("b_gnt", gnt, 4'b0100);
    chk2("b_sel", sel, 2'd2);
    chk1("b_yv0", y_valid, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      dv = 8'h10 + 8'(i);
      d2 = dv;
      tick();
      chk1("b_yv", y_valid, 1'b1);
      chk8("b_y", y, dv);
      chk4("b_gnt_run", gnt, (i == 4) ? 4'b0000 : 4'b0100);
    end
    chk1("b_idle_busy", busy, 1'b0);
    d2 = 8'h15;
    tick();
    chk4("b_regnt", gnt, 4'b0100);
    chk1("b_regnt_yv", y_valid, 1'b0);
    d2 = 8'h16;
    tick();
    chk8("b_y5", y, 8'h16);
    req = 4'b0000;
    tick();
    chk1("b_drop_yv", y_valid, 1'b0);
    chk8("b_drop_y", y, 8'h16);
    chk1("b_drop_busy", busy, 1'b0);
    chk2("b_sel_hold", sel, 2'd2);

    // round robin from ptr 0 with all requesters active
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dat[0] = 8'hA0; dat[1] = 8'hB1; dat[2] = 8'hC2; dat[3] = 8'hD3;
    d0 = dat[0]; d1 = dat[1]; d2 = dat[2]; d3 = dat[3];
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      gv = 2'(k % 4);
      tick();
      chk4("c_gnt", gnt, 4'b0001 << gv);
      chk2("c_sel", sel, gv);
      chk1("c_yv0", y_valid, 1'b0);
      for (int j = 1; j <= 4; j++) begin
        tick();
        chk1("c_yv", y_valid, 1'b1);
        chk8("c_y", y, dat[gv]);
        chk4("c_gnt_run", gnt, (j == 4) ? 4'b0000 : (4'b0001 << gv));
      end
    end
    req = 4'b0000;
    tick();

    // early drop after two words, then pending 3 beats 0
    req = 4'b0010;
    tick();
    chk4("d_gnt", gnt, 4'b0010);
    d1 = 8'h21;
    tick();
    chk8("d_y1", y, 8'h21);
    chk1("d_yv1", y_valid, 1'b1);
    d1 = 8'h22;
    tick();
    chk8("d_y2", y, 8'h22);
    chk1("d_yv2", y_valid, 1'b1);
    req = 4'b1001;
    tick();
    chk1("d_drop_yv", y_valid, 1'b0);
    chk8("d_drop_y", y, 8'h22);
    chk4("d_drop_gnt", gnt, 4'b0000);
    chk2("d_ptr", dut.r_ptr, 2'd2);
    tick();
    chk4("d_gnt3", gnt, 4'b1000);
    chk2("d_sel3", sel, 2'd3);
    req = 4'b0000;
    tick();
    chk1("d_rel_busy", busy, 1'b0);
    tick();

    // drop coinciding with the hold limit
    req = 4'b0001;
    tick();
    chk4("e_gnt", gnt, 4'b0001);
    for (int i = 1; i <= 3; i++) begin
      dv = 8'h30 + 8'(i);
      d0 = dv;
      tick();
      chk1("e_yv", y_valid, 1'b1);
      chk8("e_y", y, dv);
    end
    req = 4'b0000; d0 = 8'h34;
    tick();
    chk1("e_lim_yv", y_valid, 1'b0);
    chk8("e_lim_y", y, 8'h33);
    chk1("e_lim_busy", busy, 1'b0);
    chk4("e_lim_gnt", gnt, 4'b0000);
    tick();

    // one word per grant, alternating between 0 and 1
    d0 = 8'hE0; d1 = 8'hE1;
    req1 = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      gv = 2'(k % 2);
      tick();
      chk4("f_gnt", gnt1, 4'b0001 << gv);
      chk1("f_busy", busy1, 1'b1);
      chk1("f_yv0", y_valid1, 1'b0);
      tick();
      chk1("f_yv", y_valid1, 1'b1);
      chk8("f_y", y1, (gv == 2'd0) ? 8'hE0 : 8'hE1);
      chk4("f_rel", gnt1, 4'b0000);
      chk1("f_idle", busy1, 1'b0);
    end
    req1 = 4'b0000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
